// File: rtl/vt_sensor_readout_avg.sv
// Readout stage for the ripple-counter sensor: synchronizes TXDV, captures CNT once per
// conversion, averages 2^AVG_LOG2 conversions and presents the mean on a valid/ready port.
module vt_sensor_readout_avg #(
  parameter int AVG_LOG2    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RSTHIGH,
  input  logic        TXDV,
  input  logic [15:0] CNT,
  input  logic        CLR,
  input  logic        OUT_READY,
  output logic [15:0] AVG_OUT,
  output logic        OUT_VALID,
  output logic [15:0] LAST_CNT,
  output logic        OVERRUN
);

  localparam int ACC_W = 16 + AVG_LOG2;
  localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << AVG_LOG2) - 1);

  // Each state's work is registered on the edge that leaves it: CNT is captured when
  // IDLE sees a rise, the accumulator is updated when CAPT exits, ACCUM is the recovery slot.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CAPT  = 2'd1;
  localparam logic [1:0] ST_ACCUM = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   txdv_d_q;
  logic                   txdv_s;
  logic                   rise;

  logic [1:0]       state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      last_q, last_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      avg_q, avg_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [ACC_W-1:0] sum;
  logic [15:0]      result;

  assign txdv_s = sync_q[SYNC_STAGES-1];
  assign rise   = txdv_s & ~txdv_d_q;
  assign sum    = acc_q + ACC_W'(cnt_q);
  assign result = 16'(sum >> AVG_LOG2);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    avg_d   = avg_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (valid_q && OUT_READY) valid_d = 1'b0;

    if (CLR) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            cnt_d   = CNT;
            last_d  = CNT;
            state_d = ST_CAPT;
          end
        end
        ST_CAPT: begin
          state_d = ST_ACCUM;
          if (idx_q == LAST_IDX) begin
            acc_d = '0;
            idx_d = '0;
            if (!valid_q || OUT_READY) begin
              avg_d   = result;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            acc_d = sum;
            idx_d = idx_q + IDX_W'(1);
          end
        end
        ST_ACCUM: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RSTHIGH) begin
    if (RSTHIGH) begin
      sync_q   <= '0;
      txdv_d_q <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      avg_q    <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], TXDV};
      txdv_d_q <= txdv_s;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      avg_q    <= avg_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign AVG_OUT   = avg_q;
  assign OUT_VALID = valid_q;
  assign LAST_CNT  = last_q;
  assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_vt_sensor_readout_avg.sv
// Directed bench for vt_sensor_readout_avg: a 4-sample averager plus pass-through
// instances with 2- and 3-stage synchronizers, all sharing one set of inputs.
module tb_vt_sensor_readout_avg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        txdv = 1'b0;
  logic [15:0] cnt = '0;
  logic        clr = 1'b0;
  logic        rdy = 1'b0;

  logic [15:0] avg_m, last_m, avg_p, last_p, avg_s, last_s;
  logic        val_m, ovr_m, val_p, ovr_p, val_s, ovr_s;

  int checks = 0;
  int failures = 0;
  int lat_m, lat_p, lat_s;
  int vcnt_m, vcnt_p, vcnt_s;

  always #5 clk = ~clk;

  vt_sensor_readout_avg #(.AVG_LOG2(2), .SYNC_STAGES(2)) dut_m (
    .CLK(clk), .RSTHIGH(rst), .TXDV(txdv), .CNT(cnt), .CLR(clr), .OUT_READY(rdy),
    .AVG_OUT(avg_m), .OUT_VALID(val_m), .LAST_CNT(last_m), .OVERRUN(ovr_m));

  vt_sensor_readout_avg #(.AVG_LOG2(0), .SYNC_STAGES(2)) dut_p (
    .CLK(clk), .RSTHIGH(rst), .TXDV(txdv), .CNT(cnt), .CLR(clr), .OUT_READY(rdy),
    .AVG_OUT(avg_p), .OUT_VALID(val_p), .LAST_CNT(last_p), .OVERRUN(ovr_p));

  vt_sensor_readout_avg #(.AVG_LOG2(0), .SYNC_STAGES(3)) dut_s (
    .CLK(clk), .RSTHIGH(rst), .TXDV(txdv), .CNT(cnt), .CLR(clr), .OUT_READY(rdy),
    .AVG_OUT(avg_s), .OUT_VALID(val_s), .LAST_CNT(last_s), .OVERRUN(ovr_s));

  // One conversion: CNT set a cycle ahead, TXDV high for 'high' cycles, then 4 low cycles.
  // Latency is counted in falling edges after TXDV is driven high; rdy_at / clr_at pulse
  // OUT_READY / CLR for one cycle starting at that falling edge (-1 = not used).
  task automatic pulse(input logic [15:0] v, input int high, input int rdy_at, input int clr_at);
    cnt = v;
    @(negedge clk);
    txdv = 1'b1;
    lat_m = -1; lat_p = -1; lat_s = -1;
    vcnt_m = 0; vcnt_p = 0; vcnt_s = 0;
    for (int i = 1; i <= high + 4; i++) begin
      @(negedge clk);
      if (val_m) begin vcnt_m++; if (lat_m < 0) lat_m = i; end
      if (val_p) begin vcnt_p++; if (lat_p < 0) lat_p = i; end
      if (val_s) begin vcnt_s++; if (lat_s < 0) lat_s = i; end
      if (i == high) txdv = 1'b0;
      if (i == rdy_at) rdy = 1'b1;
      if (rdy_at >= 0 && i == rdy_at + 1) rdy = 1'b0;
      if (i == clr_at) clr = 1'b1;
      if (clr_at >= 0 && i == clr_at + 1) clr = 1'b0;
    end
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rdy = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({avg_m, val_m, last_m, ovr_m} !== 34'd0) begin failures++; $display("FAIL reset_held got=%h exp=0", {avg_m, val_m, last_m, ovr_m}); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if ({avg_m, val_m, last_m, ovr_m} !== 34'd0) begin failures++; $display("FAIL reset_idle_main got=%h exp=0", {avg_m, val_m, last_m, ovr_m}); end
    checks++; if ({avg_s, val_s, last_s, ovr_s} !== 34'd0) begin failures++; $display("FAIL reset_idle_s3 got=%h exp=0", {avg_s, val_s, last_s, ovr_s}); end
  endtask

  task automatic test_average();
    logic [15:0] v [4] = '{16'd100, 16'd101, 16'd102, 16'd103};
    rdy = 1'b1;
    for (int s = 0; s < 3; s++) begin
      pulse(v[s], 6, -1, -1);
      checks++; if (last_m !== v[s]) begin failures++; $display("FAIL avg_last_cnt%0d got=%0d exp=%0d", s, last_m, v[s]); end
      checks++; if (vcnt_m !== 0) begin failures++; $display("FAIL avg_early_valid%0d got=%0d exp=0", s, vcnt_m); end
    end
    pulse(v[3], 6, -1, -1);
    checks++; if (lat_m !== 4) begin failures++; $display("FAIL avg_latency got=%0d exp=4", lat_m); end
    checks++; if (vcnt_m !== 1) begin failures++; $display("FAIL avg_single_pulse got=%0d exp=1", vcnt_m); end
    checks++; if (avg_m !== 16'd101) begin failures++; $display("FAIL avg_value got=%0d exp=101", avg_m); end
    checks++; if (last_m !== 16'd103) begin failures++; $display("FAIL avg_last_cnt3 got=%0d exp=103", last_m); end
    checks++; if (val_m !== 1'b0) begin failures++; $display("FAIL avg_valid_cleared got=%0b exp=0", val_m); end
  endtask

  task automatic test_full_scale();
    logic [15:0] z [4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0003};
    rdy = 1'b1;
    for (int s = 0; s < 4; s++) pulse(16'hFFFF, 6, -1, -1);
    checks++; if (avg_m !== 16'hFFFF) begin failures++; $display("FAIL full_scale got=%h exp=ffff", avg_m); end
    checks++; if (lat_m !== 4) begin failures++; $display("FAIL full_scale_latency got=%0d exp=4", lat_m); end
    for (int s = 0; s < 4; s++) pulse(z[s], 6, -1, -1);
    checks++; if (avg_m !== 16'h0000) begin failures++; $display("FAIL truncation got=%h exp=0000", avg_m); end
    checks++; if (vcnt_m !== 1) begin failures++; $display("FAIL truncation_pulse got=%0d exp=1", vcnt_m); end
  endtask

  task automatic test_backpressure();
    rdy = 1'b0;
    for (int s = 0; s < 4; s++) pulse(16'd10, 6, -1, -1);
    checks++; if (avg_m !== 16'd10 || val_m !== 1'b1) begin failures++; $display("FAIL bp_first_block got avg=%0d valid=%0b exp avg=10 valid=1", avg_m, val_m); end
    checks++; if (ovr_m !== 1'b0) begin failures++; $display("FAIL bp_no_overrun_yet got=%0b exp=0", ovr_m); end
    for (int s = 0; s < 4; s++) pulse(16'd10, 6, -1, -1);
    for (int s = 0; s < 8; s++) pulse(16'd20, 6, -1, -1);
    checks++; if (avg_m !== 16'd10) begin failures++; $display("FAIL bp_avg_held got=%0d exp=10", avg_m); end
    checks++; if (val_m !== 1'b1) begin failures++; $display("FAIL bp_valid_held got=%0b exp=1", val_m); end
    checks++; if (ovr_m !== 1'b1) begin failures++; $display("FAIL bp_overrun got=%0b exp=1", ovr_m); end
    @(negedge clk); rdy = 1'b1;
    @(negedge clk); rdy = 1'b0;
    checks++; if (val_m !== 1'b0) begin failures++; $display("FAIL bp_accept got=%0b exp=0", val_m); end
    repeat (3) @(negedge clk);
    checks++; if (ovr_m !== 1'b1) begin failures++; $display("FAIL bp_overrun_sticky got=%0b exp=1", ovr_m); end
    do_clr();
    checks++; if (ovr_m !== 1'b0) begin failures++; $display("FAIL bp_overrun_clr got=%0b exp=0", ovr_m); end
    checks++; if (avg_m !== 16'd10) begin failures++; $display("FAIL bp_clr_keeps_avg got=%0d exp=10", avg_m); end
  endtask

  task automatic test_ready_on_load();
    rdy = 1'b0;
    for (int s = 0; s < 4; s++) pulse(16'd40, 6, -1, -1);
    checks++; if (avg_m !== 16'd40 || val_m !== 1'b1) begin failures++; $display("FAIL rol_first got avg=%0d valid=%0b exp avg=40 valid=1", avg_m, val_m); end
    for (int s = 0; s < 3; s++) pulse(16'd60, 6, -1, -1);
    pulse(16'd60, 6, 3, -1);
    checks++; if (avg_m !== 16'd60) begin failures++; $display("FAIL rol_new_value got=%0d exp=60", avg_m); end
    checks++; if (val_m !== 1'b1) begin failures++; $display("FAIL rol_valid got=%0b exp=1", val_m); end
    checks++; if (ovr_m !== 1'b0) begin failures++; $display("FAIL rol_overrun got=%0b exp=0", ovr_m); end
  endtask

  task automatic test_clr_on_rise();
    do_clr();
    rdy = 1'b1;
    pulse(16'd5, 6, -1, -1);
    pulse(16'd999, 6, -1, 2);
    checks++; if (last_m !== 16'd5) begin failures++; $display("FAIL clr_rise_discard got=%0d exp=5", last_m); end
    for (int s = 0; s < 3; s++) pulse(16'd8, 6, -1, -1);
    checks++; if (vcnt_m !== 0) begin failures++; $display("FAIL clr_rise_idx got=%0d exp=0", vcnt_m); end
    pulse(16'd8, 6, -1, -1);
    checks++; if (lat_m !== 4 || avg_m !== 16'd8) begin failures++; $display("FAIL clr_rise_block got lat=%0d avg=%0d exp lat=4 avg=8", lat_m, avg_m); end
  endtask

  task automatic test_reset_mid_block();
    rdy = 1'b1;
    pulse(16'd7, 6, -1, -1);
    pulse(16'd7, 6, -1, -1);
    @(negedge clk); rst = 1'b1;
    #1;
    checks++; if ({avg_m, val_m, last_m, ovr_m} !== 34'd0) begin failures++; $display("FAIL reset_async got=%h exp=0", {avg_m, val_m, last_m, ovr_m}); end
    @(negedge clk); rst = 1'b0;
    for (int s = 0; s < 3; s++) pulse(16'd12, 6, -1, -1);
    checks++; if (vcnt_m !== 0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", vcnt_m); end
    pulse(16'd12, 6, -1, -1);
    checks++; if (lat_m !== 4 || avg_m !== 16'd12) begin failures++; $display("FAIL reset_block got lat=%0d avg=%0d exp lat=4 avg=12", lat_m, avg_m); end
  endtask

  task automatic test_pass_through();
    do_reset();
    rdy = 1'b1;
    pulse(16'd1234, 50, -1, -1);
    checks++; if (vcnt_p !== 1 || avg_p !== 16'd1234) begin failures++; $display("FAIL pt_result got pulses=%0d avg=%0d exp pulses=1 avg=1234", vcnt_p, avg_p); end
    checks++; if (lat_p !== 4) begin failures++; $display("FAIL pt_latency_sync2 got=%0d exp=4", lat_p); end
    checks++; if (vcnt_s !== 1 || avg_s !== 16'd1234) begin failures++; $display("FAIL pt_result_sync3 got pulses=%0d avg=%0d exp pulses=1 avg=1234", vcnt_s, avg_s); end
    checks++; if (lat_s !== 5) begin failures++; $display("FAIL pt_latency_sync3 got=%0d exp=5", lat_s); end
    checks++; if (last_m !== 16'd1234 || vcnt_m !== 0) begin failures++; $display("FAIL pt_main_single got last=%0d pulses=%0d exp last=1234 pulses=0", last_m, vcnt_m); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_average();
    test_full_scale();
    test_backpressure();
    test_ready_on_load();
    test_clr_on_rise();
    test_reset_mid_block();
    test_pass_through();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
